reduce_val_dropper: RTL and testbench
=====================================

Name: reduce_val_dropper

Overview:
- Sits directly downstream of reduce_pe_cluster and consumes its 17-bit output value stream (reduce_data_out / valid / ready).
- Removes data tokens equal to a configured drop value (normally the reduce default value 0), so empty reductions produce no explicit zeros downstream.
- Passes stop and done tokens unchanged, buffers through a small output FIFO, and keeps pass/drop statistics for the glb_read side.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2)
- CNT_W, 16, width of the passed/dropped counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  when 0, all state frozen
- tile_en  in  1  enables the block; 0 holds it idle
- flush  in  1  synchronous soft clear for a new tile
- drop_value  in  16  data value to discard
- data_in  in  17  token from reduce; bit16=0 data [15:0]; bit16=1 control
- data_in_valid  in  1  upstream valid
- data_in_ready  out  1  this block ready
- data_out  out  17  token to downstream
- data_out_valid  out  1  downstream valid
- data_out_ready  in  1  downstream ready
- passed_count  out  CNT_W  data tokens forwarded this tile
- dropped_count  out  CNT_W  data tokens discarded this tile
- done_seen  out  1  done token accepted this tile

Behaviour:
- Token encoding: control tokens have bit16=1.
  - [9:8]=00 is stop, level in [7:0].
  - [9:8]=01 is done; the canonical value is 17'h10100.
  - Other control codes are forwarded as-is and do not change state.
- States: IDLE, RUN, DONE.
  - rst -> IDLE, FIFO empty, counters 0, done_seen 0, data_out 0, data_out_valid 0, data_in_ready 0.
  - IDLE -> RUN when tile_en=1 and clk_en=1.
  - RUN -> DONE on the cycle a done token is accepted.
  - Any state -> IDLE when tile_en=0; FIFO contents are retained.
  - DONE holds until flush or rst.
- Input acceptance:
  - data_in_ready = clk_en & tile_en & (state==RUN) & (fifo_count<DEPTH).
  - It is independent of the token value and of data_out_ready, with no combinational in->out path.
  - An input handshake occurs when data_in_valid & data_in_ready.
- On handshake:
  - Data token with value==drop_value: not written; dropped_count += 1.
  - Other data token: written to FIFO; passed_count += 1.
  - Control token: written to FIFO; counters unchanged.
  - Done token: also sets done_seen=1 and enters DONE; data_in_ready drops the next cycle.
- Output:
  - data_out_valid = clk_en & (fifo_count>0); data_out is the FIFO head, registered.
  - Pop when valid & data_out_ready.
  - Draining continues in DONE and IDLE; only clk_en=0 stalls it.
  - Latency: an accepted token is visible on data_out at the earliest 1 cycle after acceptance.
  - Simultaneous push and pop at fifo_count==DEPTH is impossible because ready is 0. At other counts, simultaneous push and pop leaves fifo_count unchanged.
  - Ordering is strictly preserved; pointers wrap modulo DEPTH.
  - With DEPTH=2 and downstream always ready, 1 token/cycle is sustained.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Dropping a fiber's only data token still forwards its stop token; an empty fiber is represented by a bare stop.
- flush (any state, overrides everything except rst):
  - Empties the FIFO and clears counters and done_seen.
  - Next state is RUN if tile_en, else IDLE.
  - data_out_valid is 0 the cycle after.
  - The input handshake in the flush cycle is ignored.
- rst mid-stream discards all buffered tokens; the outputs return to reset values the next cycle.
- clk_en=0: registers hold, and data_in_ready=0 and data_out_valid=0 combinationally.
- drop_value is sampled per token; changing it mid-tile affects subsequent tokens only.

Test Plan:
- Pass-through: drop_value=0, ready=1; stream 0x00005, 0x00000, 0x00007, 0x10000 (S0), 0x10100 (done).
  - Output is 0x00005, 0x00007, 0x10000, 0x10100.
  - passed=2, dropped=1, done_seen=1; data_in_ready=0 afterwards.
- Empty fiber: stream 0x00000, 0x10001 (S1), 0x10100 -> output 0x10001, 0x10100; dropped=1, passed=0.
- Backpressure: data_out_ready=0 for 5 cycles while sending 0x00001, 0x00002, 0x00003.
  - data_in_ready falls after 2 accepts.
  - Releasing ready yields 1, 2, 3 in order with no loss or duplication.
- Random ready toggling (p=0.5) over 200 tokens: the output equals the reference-filtered sequence, and the counters match the filtered counts.
- Flush mid-stream: 2 tokens buffered, then a 1-cycle flush.
  - data_out_valid=0 next cycle and the counters are 0.
  - A following token 0x00009 emerges alone.
- Reset/clk_en: rst asserted with FIFO full -> all outputs 0 next cycle.
  - clk_en=0 for 3 cycles during streaming -> valid/ready are 0 and the sequence resumes intact.
  - A counter preset near max saturates at 0xFFFF.

Source files
------------

// File: rtl/reduce_val_dropper_if.sv
// rtl/reduce_val_dropper_if.sv - token stream bundle between reduce, the dropper and downstream
interface reduce_val_dropper_if;
  logic [16:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [16:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/reduce_val_dropper.sv
// rtl/reduce_val_dropper.sv - drops reduce data tokens equal to drop_value, forwards control tokens via a small FIFO
module reduce_val_dropper #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               tile_en,
  input  logic               flush,
  input  logic [15:0]        drop_value,
  reduce_val_dropper_if.slave bus,
  output logic [CNT_W-1:0]   passed_count,
  output logic [CNT_W-1:0]   dropped_count,
  output logic               done_seen
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        state_n;
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic is_ctrl;
  logic is_done;
  logic is_drop;
  logic in_ready;
  logic out_valid;
  logic hs;
  logic push;
  logic pop;

  // Ready depends only on registered state, never on the token or on data_out_ready.
  always_comb begin
    is_ctrl   = bus.data_in[16];
    is_done   = is_ctrl && (bus.data_in[9:8] == 2'b01);
    is_drop   = !is_ctrl && (bus.data_in[15:0] == drop_value);
    in_ready  = clk_en && tile_en && (state == RUN) && (count < FULL);
    out_valid = clk_en && (count != '0);
    hs        = in_ready && bus.data_in_valid;
    push      = hs && !is_drop;
    pop       = out_valid && bus.data_out_ready;
  end

  assign bus.data_in_ready  = in_ready;
  assign bus.data_out_valid = out_valid;
  assign bus.data_out       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // flush is a soft clear that wins over clk_en; everything else freezes when clk_en is low.
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = tile_en ? RUN : IDLE;
    end else if (clk_en) begin
      if (!tile_en) begin
        state_n = IDLE;
      end else begin
        case (state)
          IDLE:    state_n = RUN;
          RUN:     if (hs && is_done) state_n = DONE;
          DONE:    state_n = DONE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      passed_count  <= '0;
      dropped_count <= '0;
      done_seen     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      passed_count  <= '0;
      dropped_count <= '0;
      done_seen     <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Counters stick at all-ones rather than wrapping.
      if (hs && !is_ctrl) begin
        if (is_drop) begin
          if (dropped_count != '1) dropped_count <= dropped_count + 1'b1;
        end else begin
          if (passed_count != '1) passed_count <= passed_count + 1'b1;
        end
      end
      if (hs && is_done) done_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reduce_val_dropper.sv
// tb/tb_reduce_val_dropper.sv - scoreboard bench for reduce_val_dropper with a filtered-sequence reference model
module tb_reduce_val_dropper;
  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        tile_en;
  logic        flush;
  logic [15:0] drop_value;
  logic [15:0] passed_count;
  logic [15:0] dropped_count;
  logic        done_seen;
  logic [3:0]  passed2;
  logic [3:0]  dropped2;
  logic        done2;

  reduce_val_dropper_if bus ();
  reduce_val_dropper_if bus2 ();

  reduce_val_dropper #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tile_en(tile_en), .flush(flush),
    .drop_value(drop_value), .bus(bus.slave),
    .passed_count(passed_count), .dropped_count(dropped_count), .done_seen(done_seen)
  );

  reduce_val_dropper #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tile_en(tile_en), .flush(flush),
    .drop_value(drop_value), .bus(bus2.slave),
    .passed_count(passed2), .dropped_count(dropped2), .done_seen(done2)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  int          exp_pass;
  int          exp_drop;
  int          ready_mode = 1;
  bit          mon_en = 1'b1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.data_out_ready = 1'b0;
      1:       bus.data_out_ready = 1'b1;
      default: bus.data_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: every downstream handshake must match the oldest expected token.
  always @(negedge clk) begin : monitor
    logic [16:0] e;
    if (mon_en && bus.data_out_valid && bus.data_out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %05h, expected no token", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL out_token: got %05h, expected %05h", bus.data_out, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: data equal to drop_value vanishes, everything else is forwarded verbatim.
  task automatic model_push(input logic [16:0] tok);
    if (!tok[16] && tok[15:0] == drop_value) begin
      if (exp_drop < 65535) exp_drop++;
    end else begin
      exp_q.push_back(tok);
      if (!tok[16] && exp_pass < 65535) exp_pass++;
    end
  endtask

  task automatic send(input logic [16:0] tok);
    bit ok = 1'b0;
    bus.data_in       = tok;
    bus.data_in_valid = 1'b1;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (bus.data_in_ready) begin
        model_push(tok);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.data_in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no ready, expected accept of %05h", tok);
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int w = 0; w < 400 && !ok; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.data_out_valid) ok = 1'b1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic new_tile();
    mon_en = 1'b0;
    flush  = 1'b1;
    exp_q.delete();
    exp_pass = 0;
    exp_drop = 0;
    @(posedge clk); #1;
    flush  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    logic [16:0] bp_toks [3];
    int          idx;
    logic        rdy_seen;
    rst = 1'b1; clk_en = 1'b1; tile_en = 1'b0; flush = 1'b0; drop_value = 16'h0;
    bus.data_in = '0; bus.data_in_valid = 1'b0;
    bus2.data_in = '0; bus2.data_in_valid = 1'b0; bus2.data_out_ready = 1'b1;
    exp_pass = 0; exp_drop = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.data_out_valid), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_in_ready", 32'(bus.data_in_ready), 0);
    chk("rst_passed", 32'(passed_count), 0);
    chk("rst_dropped", 32'(dropped_count), 0);
    chk("rst_done", 32'(done_seen), 0);
    @(posedge clk); #1;
    tile_en = 1'b1;

    // Pass-through
    ready_mode = 1;
    new_tile();
    send(17'h00005); send(17'h00000); send(17'h00007); send(17'h10000); send(17'h10100);
    wait_drain();
    @(negedge clk);
    chk("pt_passed", 32'(passed_count), 2);
    chk("pt_dropped", 32'(dropped_count), 1);
    chk("pt_done", 32'(done_seen), 1);
    chk("pt_in_ready_after_done", 32'(bus.data_in_ready), 0);
    @(posedge clk); #1;

    // Empty fiber
    new_tile();
    send(17'h00000); send(17'h10001); send(17'h10100);
    wait_drain();
    @(negedge clk);
    chk("ef_passed", 32'(passed_count), 0);
    chk("ef_dropped", 32'(dropped_count), 1);
    chk("ef_done", 32'(done_seen), 1);
    @(posedge clk); #1;

    // Backpressure: two accepts fill the FIFO, the third waits
    ready_mode = 0;
    new_tile();
    bp_toks[0] = 17'h00001; bp_toks[1] = 17'h00002; bp_toks[2] = 17'h00003;
    idx = 0;
    rdy_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) begin
        bus.data_in = bp_toks[idx];
        bus.data_in_valid = 1'b1;
      end
      @(negedge clk);
      rdy_seen = bus.data_in_ready;
      if (bus.data_in_valid && bus.data_in_ready) begin
        model_push(bp_toks[idx]);
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.data_in_valid = 1'b0;
    chk("bp_accepts", 32'(idx), 2);
    chk("bp_ready_low", 32'(rdy_seen), 0);
    ready_mode = 1;
    send(bp_toks[2]);
    wait_drain();
    @(negedge clk);
    chk("bp_passed", 32'(passed_count), 3);
    @(posedge clk); #1;

    // Random ready, random tokens, occasional drop_value changes
    ready_mode = 2;
    new_tile();
    for (int i = 0; i < 200; i++) begin
      int          r;
      logic [16:0] t;
      r = int'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) drop_value = 16'($urandom_range(0, 2));
      if (r < 4)       t = {1'b0, 16'($urandom_range(0, 3))};
      else if (r < 6)  t = {1'b0, 16'($urandom)};
      else if (r == 6) t = {1'b1, 6'd0, 2'b00, 8'($urandom)};
      else             t = {1'b1, 6'($urandom), 1'b1, 1'($urandom), 8'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(t);
    end
    send(17'h10100);
    wait_drain();
    @(negedge clk);
    chk("rnd_passed", 32'(passed_count), 32'(exp_pass));
    chk("rnd_dropped", 32'(dropped_count), 32'(exp_drop));
    chk("rnd_done", 32'(done_seen), 1);
    @(posedge clk); #1;
    drop_value = 16'h0;

    // Flush with two tokens buffered
    ready_mode = 0;
    new_tile();
    send(17'h00001); send(17'h00002);
    new_tile();
    @(negedge clk);
    chk("fl_valid", 32'(bus.data_out_valid), 0);
    chk("fl_passed", 32'(passed_count), 0);
    chk("fl_dropped", 32'(dropped_count), 0);
    @(posedge clk); #1;
    ready_mode = 1;
    send(17'h00009);
    wait_drain();

    // Reset with the FIFO full
    ready_mode = 0;
    new_tile();
    send(17'h00011); send(17'h00012);
    mon_en = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rr_valid", 32'(bus.data_out_valid), 0);
    chk("rr_data_out", 32'(bus.data_out), 0);
    chk("rr_in_ready", 32'(bus.data_in_ready), 0);
    chk("rr_passed", 32'(passed_count), 0);
    chk("rr_done", 32'(done_seen), 0);
    @(posedge clk); #1;

    // clk_en low for 3 cycles mid-stream
    ready_mode = 1;
    new_tile();
    fork
      begin
        for (int i = 0; i < 8; i++) send({1'b0, 16'(i + 1)});
      end
      begin
        repeat (3) @(posedge clk);
        #1 clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("ce_valid", 32'(bus.data_out_valid), 0);
          chk("ce_ready", 32'(bus.data_in_ready), 0);
        end
        @(posedge clk); #1;
        clk_en = 1'b1;
      end
    join
    wait_drain();
    @(negedge clk);
    chk("ce_passed", 32'(passed_count), 8);
    @(posedge clk); #1;

    // Saturation on the narrow-counter instance
    new_tile();
    bus2.data_in = 17'h00001;
    bus2.data_in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus2.data_in = 17'h00000;
    repeat (20) @(posedge clk);
    #1 bus2.data_in_valid = 1'b0;
    @(negedge clk);
    chk("sat_passed", 32'(passed2), 15);
    chk("sat_dropped", 32'(dropped2), 15);
    chk("sat_done", 32'(done2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
